// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Owns the program counter, drives the byte address into a combinational,
// little-endian, byte-addressed instruction memory, and captures the
// returned word plus its PC into a small prefetch queue. The queue head is
// presented to decode over a valid/ready handshake. A redirect loads a new
// PC and flushes the queue.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned target flushes the queue,
//               parks the unit in FAULT (left only by rst), and latches
//               misalign_err / fault_pc.
//   undefined : redirect_pc[1:0] is forced to 2'b00 on load; misalign_err
//               and fault_pc are tied to 0.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   im_addr         byte address to instruction memory (= fetch_pc)
//   im_inst         instruction word for im_addr, same cycle
//   redirect_valid  load redirect_pc and flush the queue
//   redirect_pc     redirect target byte address
//   out_valid       queue head valid toward decode
//   out_ready       decode accepts the head this cycle
//   out_inst        head instruction
//   out_pc          head PC
//   out_pc_plus4    out_pc + 4 (mod 2^32)
//   misalign_err    sticky alignment fault
//   fault_pc        offending redirect target

module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_addr,
  input  logic [31:0] im_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        misalign_err,
  output logic [31:0] fault_pc
);

  localparam int          AW    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = QUEUE_DEPTH[AW:0];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t        state, state_nxt;
  entry_t        q [QUEUE_DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   count;
  logic [31:0]   fetch_pc;

  logic          pop, push, redir, bad_align;
  logic [31:0]   target;
  entry_t        head;

`ifdef FETCH_ALIGN_CHECK_EN
  assign bad_align = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign target    = redirect_pc;
`else
  assign bad_align = 1'b0;
  assign target    = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Redirects are only honoured while running; FAULT ignores them.
  assign redir = redirect_valid && (state == RUN);
  assign pop   = out_valid && out_ready;
  // A full queue can still accept a fetch when the head leaves this cycle.
  assign push  = (state == RUN) && !redirect_valid &&
                 ((count < DEPTH) || ((count == DEPTH) && pop));

  assign im_addr = fetch_pc;

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    if (state == RUN && redir && bad_align) state_nxt = FAULT;
  end

  // ---- FSM: outputs ----
  always_comb begin
    head         = q[rptr];
    out_valid    = (count != '0) && (state == RUN);
    out_inst     = head.inst;
    out_pc       = head.pc;
    out_pc_plus4 = head.pc + 32'd4;
  end

  // ---- PC, queue storage, pointers, occupancy ----
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
    end else if (redir) begin
      // Flush; a same-cycle pop was accepted by decode but is simply dropped.
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      if (!bad_align) fetch_pc <= target;
    end else begin
      if (push) begin
        q[wptr]  <= '{pc: fetch_pc, inst: im_inst};
        wptr     <= wptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- sticky alignment fault ----
`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
      fault_pc     <= '0;
    end else if (redir && bad_align) begin
      misalign_err <= 1'b1;
      fault_pc     <= redirect_pc;
    end
  end
`else
  assign misalign_err = 1'b0;
  assign fault_pc     = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing checks from the stimulus process plus
// a scoreboard monitor that tracks the expected program-order PC stream.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_addr, im_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc, out_pc_plus4;
  logic        misalign_err;
  logic [31:0] fault_pc;

  int n_total = 0;
  int n_pass  = 0;
  int n_pops  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .im_addr(im_addr), .im_inst(im_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .misalign_err(misalign_err), .fault_pc(fault_pc)
  );

  // Instruction memory contents: two fixed words, hashed content elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  always_comb im_inst = mem_word(im_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Expected output order is simply consecutive words from the most recent
  // start point (reset or accepted redirect).
  logic [31:0] exp_q[$];
  logic [31:0] nxt_pc;
  bit          in_fault;

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    nxt_pc = pc;
    while (exp_q.size() < 8) begin
      exp_q.push_back(nxt_pc);
      nxt_pc = nxt_pc + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    bit          mis;
    if (rst) begin
      in_fault = 1'b0;
      restart(RPC);
    end else begin
      if (in_fault) begin
        chk("fault_out_valid", {31'b0, out_valid}, 32'd0);
      end else if (out_valid && out_ready) begin
        n_pops++;
        e = exp_q.pop_front();
        exp_q.push_back(nxt_pc);
        nxt_pc = nxt_pc + 32'd4;
        chk("sb_pc", out_pc, e);
        chk("sb_inst", out_inst, mem_word(e));
        chk("sb_pc_plus4", out_pc_plus4, e + 32'd4);
      end
      if (redirect_valid && !in_fault) begin
`ifdef FETCH_ALIGN_CHECK_EN
        mis = (redirect_pc[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (mis) begin
          in_fault = 1'b1;
          exp_q.delete();
        end else begin
          restart(redirect_pc & 32'hFFFF_FFFC);
        end
      end
    end
  end

  // ---------------- stimulus + directed checks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Returns in the first cycle after rst release (fetch of RESET_PC).
  task automatic do_reset();
    tick();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) tick();
    samp();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_im_addr", im_addr, RPC);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pc_plus4", out_pc_plus4, 32'd4);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);

    // Basic stream, ready high.
    out_ready = 1'b1;
    do_reset();
    samp(); chk("t1_c1_valid", {31'b0, out_valid}, 32'd0);
    tick(); samp();
    chk("t1_c2_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_c2_pc", out_pc, 32'h0);
    chk("t1_c2_inst", out_inst, 32'h0050_0093);
    tick(); samp();
    chk("t1_c3_pc", out_pc, 32'h4);
    chk("t1_c3_plus4", out_pc_plus4, 32'h8);
    chk("t1_c3_inst", out_inst, 32'h0010_0113);

    // Backpressure for 5 cycles.
    out_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    samp();
    chk("t2_stall_addr", im_addr, 32'h8);
    chk("t2_stall_head", out_pc, 32'h0);
    chk("t2_stall_valid", {31'b0, out_valid}, 32'd1);
    tick(); out_ready = 1'b1;
    samp(); chk("t2_resume_addr", im_addr, 32'h8);
    tick(); samp();
    chk("t2_resume_pc", out_pc, 32'h4);
    chk("t2_resume_addr2", im_addr, 32'hC);
    tick(); samp(); chk("t2_resume_pc2", out_pc, 32'h8);

    // Redirect while full with a pop in the same cycle.
    out_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    samp();
    tick(); redirect_valid = 1'b0;
    samp();
    chk("t3_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("t3_flush_addr", im_addr, 32'h40);
    tick(); samp();
    chk("t3_tgt_valid", {31'b0, out_valid}, 32'd1);
    chk("t3_tgt_pc", out_pc, 32'h40);
    repeat (3) tick();

    // Redirect to the top of the address space: wrap to 0.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect_valid = 1'b0;
    tick(); samp();
    chk("t4_top_pc", out_pc, 32'hFFFF_FFFC);
    chk("t4_top_plus4", out_pc_plus4, 32'h0);
    tick(); samp();
    chk("t4_wrap_pc", out_pc, 32'h0);

    // Misaligned redirect.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick(); redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    samp();
    chk("t5_misalign", {31'b0, misalign_err}, 32'd1);
    chk("t5_fault_pc", fault_pc, 32'h42);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(); redirect_valid = 1'b0;
    repeat (3) tick();
    samp();
    chk("t5_fault_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_sticky", {31'b0, misalign_err}, 32'd1);
    do_reset();
    samp();
    chk("t5_clr_misalign", {31'b0, misalign_err}, 32'd0);
    chk("t5_clr_fault_pc", fault_pc, 32'd0);
`else
    tick(); samp();
    chk("t5_masked_pc", out_pc, 32'h40);
    chk("t5_no_misalign", {31'b0, misalign_err}, 32'd0);
`endif

    // Reset with two entries queued.
    out_ready = 1'b0;
    do_reset();
    tick(); tick();
    rst = 1'b1;
    tick(); samp();
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_addr", im_addr, RPC);
    tick(); rst = 1'b0;

    // Randomized traffic.
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick();
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) begin
        r = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
        r = r & 32'hFFFF_FFFC;
`endif
        if ($urandom_range(3) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
        redirect_valid = 1'b1;
        redirect_pc = r;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    tick(); redirect_valid = 1'b0;
    repeat (4) tick();
    chk("progress", {31'b0, (n_pops > 100)}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
